gemm_unit: RTL and testbench

GEMM_UNIT -- requirements
Module: gemm_unit

---
 rtl/gemm_unit_pkg.sv | 25 ++
 rtl/gemm_mac_array.sv | 53 +++++
 rtl/gemm_unit.sv | 179 +++++++++++++++++
 tb/tb_gemm_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_unit_pkg.sv
// Shared types and derived constants for the tiled GEMM engine.
// Values here correspond to the default parameter set of gemm_unit.
package gemm_unit_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  localparam int unsigned GEMM_P        = 14;
  localparam int unsigned GEMM_K        = 294;
  localparam int unsigned GEMM_N        = 4116 * GEMM_P / GEMM_K;
  localparam int unsigned GEMM_NT       = GEMM_N / GEMM_P;
  localparam int unsigned GEMM_MT       = 70 / GEMM_P;
  localparam int unsigned GEMM_TILE_LAT = GEMM_K + 1 + GEMM_P;

  // Counter width helper that never collapses to zero bits.
  function automatic int unsigned cw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gemm_mac_array.sv
// P x P grid of unsigned multiply-accumulate cells with a saturated row read port.
// One cycle of 'en' adds the outer product of row_vec and col_vec to every cell.
module gemm_mac_array
  import gemm_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PSUM_WIDTH = 32,
  parameter int unsigned PE_SIZE    = 14,
  parameter int unsigned ROW_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          clr,
  input  logic [PE_SIZE*DATA_WIDTH-1:0] row_vec,
  input  logic [PE_SIZE*DATA_WIDTH-1:0] col_vec,
  input  logic [ROW_W-1:0]              row_sel,
  output logic [PE_SIZE*DATA_WIDTH-1:0] row_out
);

  localparam logic [PSUM_WIDTH-1:0] SAT_MAX = PSUM_WIDTH'((1 << DATA_WIDTH) - 1);

  logic [PSUM_WIDTH-1:0] acc [PE_SIZE][PE_SIZE];

  function automatic logic [DATA_WIDTH-1:0] sat(input logic [PSUM_WIDTH-1:0] v);
    return (v > SAT_MAX) ? {DATA_WIDTH{1'b1}} : v[DATA_WIDTH-1:0];
  endfunction

  // clr restarts a tile: the first product overwrites rather than adds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(PE_SIZE); i++)
        for (int j = 0; j < int'(PE_SIZE); j++)
          acc[i][j] <= '0;
    end else if (en) begin
      for (int i = 0; i < int'(PE_SIZE); i++)
        for (int j = 0; j < int'(PE_SIZE); j++)
          acc[i][j] <= (clr ? '0 : acc[i][j])
                     + PSUM_WIDTH'(row_vec[DATA_WIDTH*(int'(PE_SIZE)-1-i) +: DATA_WIDTH])
                     * PSUM_WIDTH'(col_vec[DATA_WIDTH*(int'(PE_SIZE)-1-j) +: DATA_WIDTH]);
    end
  end

  // Element 0 of the selected row lands in the MSB byte.
  always_comb begin
    row_out = '0;
    for (int i = 0; i < int'(PE_SIZE); i++)
      if (row_sel == ROW_W'(i))
        for (int j = 0; j < int'(PE_SIZE); j++)
          row_out[DATA_WIDTH*(int'(PE_SIZE)-1-j) +: DATA_WIDTH] = sat(acc[i][j]);
  end

endmodule

// File: rtl/gemm_unit.sv
// Tiled output-stationary GEMM: streams K ifmap/weight words per P x P tile,
// then writes the saturated tile rows to the ofmap BRAM.
module gemm_unit
  import gemm_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned PSUM_WIDTH      = 32,
  parameter int unsigned PE_SIZE         = 14,
  parameter int unsigned SLICING_IDX     = 32,
  parameter int unsigned OUT_CH          = 64,
  parameter int unsigned WEIGHT_ROW_NUM  = 70,
  parameter int unsigned WEIGHT_COL_NUM  = 294,
  parameter int unsigned MEM0_DEPTH      = 4116,
  parameter int unsigned MEM0_DATA_WIDTH = 112,
  parameter int unsigned MEM0_ADDR_WIDTH = 13,
  parameter int unsigned MEM1_DEPTH      = 1470,
  parameter int unsigned MEM1_DATA_WIDTH = 112,
  parameter int unsigned MEM1_ADDR_WIDTH = 11,
  parameter int unsigned MEM2_DEPTH      = 896,
  parameter int unsigned MEM2_DATA_WIDTH = 112,
  parameter int unsigned MEM2_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       gemm_start_i,
  output logic                       mem0_ce0,
  output logic                       mem0_we0,
  output logic [MEM0_ADDR_WIDTH-1:0] mem0_addr0,
  input  logic [MEM0_DATA_WIDTH-1:0] mem0_q0_i,
  output logic                       mem1_ce0,
  output logic                       mem1_we0,
  output logic [MEM1_ADDR_WIDTH-1:0] mem1_addr0,
  input  logic [MEM1_DATA_WIDTH-1:0] mem1_q0_i,
  output logic                       mem2_ce0,
  output logic                       mem2_we0,
  output logic [MEM2_ADDR_WIDTH-1:0] mem2_addr0,
  output logic [MEM2_DATA_WIDTH-1:0] mem2_d0,
  output logic                       finish_o
);

  localparam int unsigned P     = PE_SIZE;
  localparam int unsigned K     = WEIGHT_COL_NUM;
  localparam int unsigned N     = MEM0_DEPTH * P / K;
  localparam int unsigned NT    = N / P;
  localparam int unsigned MT    = WEIGHT_ROW_NUM / P;
  localparam int unsigned CNT_W = cw(K > P ? K : P);
  localparam int unsigned MT_W  = cw(MT);
  localparam int unsigned NT_W  = cw(NT);
  localparam int unsigned ROW_W = cw(P);

  if (MEM0_DATA_WIDTH != P * DATA_WIDTH || MEM1_DATA_WIDTH != P * DATA_WIDTH ||
      MEM2_DATA_WIDTH != P * DATA_WIDTH) begin : g_bad_width
    $error("gemm_unit: BRAM word width must hold one P-element vector");
  end
  if (MEM1_DEPTH != MT * K || MEM2_DEPTH != OUT_CH * NT || OUT_CH > WEIGHT_ROW_NUM ||
      SLICING_IDX > PSUM_WIDTH) begin : g_bad_geom
    $error("gemm_unit: inconsistent memory geometry");
  end

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [MT_W-1:0]   mt, mt_n;
  logic [NT_W-1:0]   nt, nt_n;
  logic              acc_en, acc_clr;
  logic              ld_n, wr_en_n;
  logic [31:0]       oc_n;
  logic [MEM0_ADDR_WIDTH-1:0] addr0_n;
  logic [MEM1_ADDR_WIDTH-1:0] addr1_n;
  logic [MEM2_ADDR_WIDTH-1:0] addr2_n;
  logic [MEM2_DATA_WIDTH-1:0] row_data;

  // Next-state, tile counters and next values of the registered BRAM controls.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mt_n    = mt;
    nt_n    = nt;
    case (state)
      IDLE: if (gemm_start_i) begin
        state_n = LOAD;
        cnt_n   = '0;
        mt_n    = '0;
        nt_n    = '0;
      end
      LOAD: if (cnt == CNT_W'(K - 1)) begin
        state_n = DRAIN;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
      DRAIN: begin
        state_n = WRITE;
        cnt_n   = '0;
      end
      WRITE: if (cnt == CNT_W'(P - 1)) begin
        cnt_n = '0;
        if (mt == MT_W'(MT - 1) && nt == NT_W'(NT - 1)) begin
          state_n = DONE;
        end else begin
          state_n = LOAD;
          if (nt == NT_W'(NT - 1)) begin
            nt_n = '0;
            mt_n = mt + MT_W'(1);
          end else begin
            nt_n = nt + NT_W'(1);
          end
        end
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
      DONE: if (!gemm_start_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    ld_n    = (state_n == LOAD);
    oc_n    = 32'(mt_n) * P + 32'(cnt_n);
    wr_en_n = (state_n == WRITE) && (oc_n < OUT_CH);
    addr0_n = ld_n ? MEM0_ADDR_WIDTH'(32'(nt_n) * K + 32'(cnt_n)) : '0;
    addr1_n = ld_n ? MEM1_ADDR_WIDTH'(32'(mt_n) * K + 32'(cnt_n)) : '0;
    addr2_n = wr_en_n ? MEM2_ADDR_WIDTH'(oc_n * NT + 32'(nt_n)) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      mt         <= '0;
      nt         <= '0;
      mem0_ce0   <= 1'b0;
      mem0_addr0 <= '0;
      mem1_ce0   <= 1'b0;
      mem1_addr0 <= '0;
      mem2_ce0   <= 1'b0;
      mem2_we0   <= 1'b0;
      mem2_addr0 <= '0;
      finish_o   <= 1'b0;
      acc_en     <= 1'b0;
      acc_clr    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      mt         <= mt_n;
      nt         <= nt_n;
      mem0_ce0   <= ld_n;
      mem0_addr0 <= addr0_n;
      mem1_ce0   <= ld_n;
      mem1_addr0 <= addr1_n;
      mem2_ce0   <= wr_en_n;
      mem2_we0   <= wr_en_n;
      mem2_addr0 <= addr2_n;
      finish_o   <= (state == DONE);
      acc_en     <= (state == LOAD);
      acc_clr    <= (state == LOAD) && (cnt == '0);
    end
  end

  assign mem0_we0 = 1'b0;
  assign mem1_we0 = 1'b0;

  gemm_mac_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .PSUM_WIDTH (PSUM_WIDTH),
    .PE_SIZE    (P),
    .ROW_W      (ROW_W)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (acc_en),
    .clr     (acc_clr),
    .row_vec (mem1_q0_i),
    .col_vec (mem0_q0_i),
    .row_sel (ROW_W'(cnt)),
    .row_out (row_data)
  );

  // Muxed straight from the accumulator flops so the last DRAIN accumulate is visible in row 0.
  assign mem2_d0 = mem2_ce0 ? row_data : '0;

endmodule

// File: tb/tb_gemm_unit.sv
// Self-checking bench for gemm_unit: BRAM models, matrix reference model,
// latency/handshake checks and a mid-job reset.
module tb_gemm_unit;
  import gemm_unit_pkg::*;

  localparam int unsigned P  = GEMM_P;
  localparam int unsigned K  = GEMM_K;
  localparam int unsigned N  = GEMM_N;
  localparam int unsigned NT = GEMM_NT;
  localparam int unsigned MT = GEMM_MT;
  localparam int unsigned M  = 70;
  localparam int unsigned OC = 64;
  localparam int unsigned D0 = 4116;
  localparam int unsigned D1 = 1470;
  localparam int unsigned D2 = 896;
  localparam int          LAT = int'(MT * NT * GEMM_TILE_LAT) + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         gemm_start_i;
  logic         mem0_ce0, mem0_we0, mem1_ce0, mem1_we0, mem2_ce0, mem2_we0, finish_o;
  logic [12:0]  mem0_addr0;
  logic [10:0]  mem1_addr0;
  logic [9:0]   mem2_addr0;
  logic [111:0] mem0_q, mem1_q, mem2_d0;

  always #5 clk = ~clk;

  gemm_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gemm_start_i (gemm_start_i),
    .mem0_ce0     (mem0_ce0),
    .mem0_we0     (mem0_we0),
    .mem0_addr0   (mem0_addr0),
    .mem0_q0_i    (mem0_q),
    .mem1_ce0     (mem1_ce0),
    .mem1_we0     (mem1_we0),
    .mem1_addr0   (mem1_addr0),
    .mem1_q0_i    (mem1_q),
    .mem2_ce0     (mem2_ce0),
    .mem2_we0     (mem2_we0),
    .mem2_addr0   (mem2_addr0),
    .mem2_d0      (mem2_d0),
    .finish_o     (finish_o)
  );

  logic [111:0] mem0 [D0];
  logic [111:0] mem1 [D1];
  logic [111:0] mem2 [D2];
  bit           written [D2];
  int           wr_cnt, dup_cnt, bad_cnt;
  int unsigned  xm [K][N];
  int unsigned  wm [M][K];
  int           n_chk, n_pass;

  // Synchronous-read BRAMs and ofmap write capture.
  always @(posedge clk) begin
    if (mem0_ce0) mem0_q <= mem0[mem0_addr0];
    if (mem1_ce0) mem1_q <= mem1[mem1_addr0];
    if (mem0_we0 || mem1_we0 || (mem2_ce0 != mem2_we0)) bad_cnt++;
    if (mem2_we0) begin
      if (mem2_addr0 >= 10'(D2)) bad_cnt++;
      else begin
        if (written[mem2_addr0]) dup_cnt++;
        written[mem2_addr0] = 1'b1;
        mem2[mem2_addr0]    = mem2_d0;
      end
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // mode 0: all ones, 1: X only at k=0 with W[m][0]=m, 2: random 0..3
  task automatic fill(input int mode);
    logic [111:0] w;
    for (int k = 0; k < int'(K); k++)
      for (int n = 0; n < int'(N); n++)
        xm[k][n] = (mode == 0) ? 1 : (mode == 1) ? ((k == 0) ? 1 : 0) : $urandom_range(3);
    for (int m = 0; m < int'(M); m++)
      for (int k = 0; k < int'(K); k++)
        wm[m][k] = (mode == 0) ? 1 : (mode == 1) ? ((k == 0) ? m : $urandom_range(255))
                                               : $urandom_range(3);
    for (int t = 0; t < int'(NT); t++)
      for (int k = 0; k < int'(K); k++) begin
        w = '0;
        for (int j = 0; j < int'(P); j++) w[8*(int'(P)-1-j) +: 8] = 8'(xm[k][t*int'(P)+j]);
        mem0[t*int'(K)+k] = w;
      end
    for (int t = 0; t < int'(MT); t++)
      for (int k = 0; k < int'(K); k++) begin
        w = '0;
        for (int j = 0; j < int'(P); j++) w[8*(int'(P)-1-j) +: 8] = 8'(wm[t*int'(P)+j][k]);
        mem1[t*int'(K)+k] = w;
      end
    for (int a = 0; a < int'(D2); a++) begin
      mem2[a]    = '0;
      written[a] = 1'b0;
    end
    wr_cnt  = 0;
    dup_cnt = 0;
  endtask

  function automatic logic [111:0] ref_word(input int oc, input int t);
    logic [111:0] w = '0;
    int unsigned  s;
    for (int j = 0; j < int'(P); j++) begin
      s = 0;
      for (int k = 0; k < int'(K); k++) s += wm[oc][k] * xm[k][t*int'(P)+j];
      w[8*(int'(P)-1-j) +: 8] = (s > 255) ? 8'hFF : 8'(s);
    end
    return w;
  endfunction

  task automatic check_all(input string tag);
    for (int oc = 0; oc < int'(OC); oc++)
      for (int t = 0; t < int'(NT); t++)
        chk($sformatf("%s y[%0d][%0d]", tag, oc, t), mem2[oc*int'(NT)+t], ref_word(oc, t));
    chk({tag, " write_count"}, wr_cnt, D2);
    chk({tag, " dup_writes"}, dup_cnt, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " ctrl"}, {finish_o, mem0_ce0, mem0_we0, mem1_ce0, mem1_we0, mem2_ce0, mem2_we0,
                         mem0_addr0, mem1_addr0, mem2_addr0}, '0);
    chk({tag, " d0"}, mem2_d0, '0);
  endtask

  // Start on the next edge; returns cycles from the sampling edge until finish_o is seen.
  task automatic run_job(input bit hold, output int cyc);
    @(negedge clk) gemm_start_i = 1'b1;
    @(posedge clk); #1;
    chk("load_first_addr", {mem0_ce0, mem1_ce0, mem0_addr0, mem1_addr0}, {2'b11, 24'd0});
    if (!hold) gemm_start_i = 1'b0;
    cyc = 0;
    while (!finish_o && cyc < 30000) begin
      @(posedge clk); #1;
      cyc++;
      if (!hold) gemm_start_i = (cyc >= 1000 && cyc < 1050);
    end
  endtask

  initial begin
    int           cyc, viol, saved;
    logic [111:0] w;
    n_chk = 0; n_pass = 0; bad_cnt = 0; wr_cnt = 0; dup_cnt = 0;
    mem0_q = '0; mem1_q = '0;
    for (int a = 0; a < int'(D0); a++) mem0[a] = '0;
    for (int a = 0; a < int'(D1); a++) mem1[a] = '0;
    gemm_start_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_outputs_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Job 1: all ones, start held high through DONE
    fill(0);
    run_job(1'b1, cyc);
    chk("ones latency", cyc, LAT);
    viol = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (!finish_o || mem0_ce0 || mem1_ce0 || mem2_ce0) viol++;
    end
    chk("done_hold", viol, 0);
    check_all("ones");
    w = {14{8'hFF}};
    chk("ones word0", mem2[0], w);
    @(negedge clk) gemm_start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("finish_drop", finish_o, 1'b0);
    viol = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (mem0_ce0 || mem1_ce0 || finish_o) viol++;
    end
    chk("idle_after_done", viol, 0);

    // Job 2: identity-like pattern, start toggled mid-job
    fill(1);
    run_job(1'b0, cyc);
    chk("diag latency", cyc, LAT);
    repeat (3) @(posedge clk);
    #1 chk("diag finish_drop", finish_o, 1'b0);
    check_all("diag");
    w = {14{8'd5}};
    chk("diag oc5", mem2[5*14+3], w);

    // Job 3: aborted by reset inside tile 10
    fill(2);
    @(negedge clk) gemm_start_i = 1'b1;
    @(posedge clk); #1 gemm_start_i = 1'b0;
    repeat (10 * GEMM_TILE_LAT + 150) @(posedge clk);
    #1;
    chk("abort pre_writes", wr_cnt, 10 * 14);
    rst_n = 1'b0;
    #1 chk_outputs_zero("abort");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    saved = wr_cnt;
    viol = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (mem0_ce0 || mem1_ce0 || mem2_ce0 || finish_o) viol++;
    end
    chk("post_abort_idle", viol, 0);
    chk("post_abort_writes", wr_cnt, saved);

    // Job 4: fresh random job after the reset
    fill(2);
    run_job(1'b0, cyc);
    chk("rand latency", cyc, LAT);
    repeat (3) @(posedge clk);
    check_all("rand");
    chk("bus_rules", bad_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
